// File: rtl/usb_pkg.sv
// Shared widths, default FIFO depth and read-strobe state encoding
// for the USB FIFO responder.
package usb_pkg;
  localparam int USB_DEPTH = 16;
  localparam int BYTE_W    = 8;
  localparam int RX_W      = BYTE_W + 1;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_ACTIVE,
    RD_UNDERRUN
  } rd_state_e;
endpackage

// File: rtl/usb_fifo_responder_sync_fifo.sv
// Show-ahead synchronous FIFO with occupancy count. The caller guarantees that
// push is only asserted when a slot is free (or a pop frees one in the same cycle).
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  assign head = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/usb_fifo_responder.sv
// Bridges a strobe-driven USB controller byte bus to two valid/ready streams
// through an RX FIFO ({cmd,byte}) and a TX FIFO, with sticky overflow/underflow flags.
module usb_fifo_responder
  import usb_pkg::*;
#(
  parameter int DEPTH = USB_DEPTH
) (
  input  logic              clkin_50,
  input  logic              cpu_resetn,
  input  logic [BYTE_W-1:0] usb_fd_in,
  output logic [BYTE_W-1:0] usb_fd_out,
  output logic              usb_fd_oe,
  input  logic              usb_cmd_data,
  input  logic              usb_wen,
  input  logic              usb_ren,
  output logic              usb_empty,
  output logic              usb_full,
  output logic [RX_W-1:0]   rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  input  logic [BYTE_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              ovf,
  output logic              unf,
  input  logic              err_clr
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic            wen_q, ren_q, wen_arm, ren_arm;
  rd_state_e       rd_state;
  logic [CW-1:0]   rx_count, tx_count;
  logic [RX_W-1:0] rx_head;
  logic [BYTE_W-1:0] tx_head;
  logic wr_edge, rd_fall, rd_rise;
  logic rx_push, rx_pop, tx_push, tx_pop;
  logic ovf_set, unf_set;

  // Arm bits stop a strobe held low across reset release from looking like a new edge.
  assign wr_edge = ~usb_wen & wen_q & wen_arm;
  assign rd_fall = ~usb_ren & ren_q & ren_arm;
  assign rd_rise = usb_ren & ~ren_q;

  assign rx_valid = (rx_count != '0);
  assign rx_pop   = rx_valid & rx_ready;
  assign rx_push  = wr_edge & ((rx_count != FULL_CNT) | rx_pop);
  assign rx_data  = rx_head;

  assign tx_pop   = rd_rise & (rd_state == RD_ACTIVE) & (tx_count != '0);
  assign tx_ready = (tx_count != FULL_CNT) | tx_pop;
  assign tx_push  = tx_valid & tx_ready;

  assign ovf_set = wr_edge & ~rx_push;
  assign unf_set = rd_fall & (tx_count == '0);

  assign usb_fd_out = (tx_count == '0) ? '0 : tx_head;
  assign usb_fd_oe  = ~ren_q;

  always_ff @(posedge clkin_50 or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      wen_q     <= 1'b1;
      ren_q     <= 1'b1;
      wen_arm   <= 1'b0;
      ren_arm   <= 1'b0;
      rd_state  <= RD_IDLE;
      usb_empty <= 1'b1;
      usb_full  <= 1'b0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
    end else begin
      wen_q     <= usb_wen;
      ren_q     <= usb_ren;
      wen_arm   <= wen_arm | usb_wen;
      ren_arm   <= ren_arm | usb_ren;
      usb_empty <= (tx_count == '0);
      usb_full  <= (rx_count == FULL_CNT);
      // A strobe that starts on an empty FIFO never pops, even if data arrives mid-strobe.
      if (rd_fall)
        rd_state <= (tx_count == '0) ? RD_UNDERRUN : RD_ACTIVE;
      else if (rd_rise)
        rd_state <= RD_IDLE;
      ovf <= ovf_set | (ovf & ~err_clr);
      unf <= unf_set | (unf & ~err_clr);
    end
  end

  sync_fifo #(.WIDTH(RX_W), .DEPTH(DEPTH)) u_rx_fifo (
    .clk       (clkin_50),
    .rst_n     (cpu_resetn),
    .push      (rx_push),
    .push_data ({usb_cmd_data, usb_fd_in}),
    .pop       (rx_pop),
    .head      (rx_head),
    .count     (rx_count)
  );

  sync_fifo #(.WIDTH(BYTE_W), .DEPTH(DEPTH)) u_tx_fifo (
    .clk       (clkin_50),
    .rst_n     (cpu_resetn),
    .push      (tx_push),
    .push_data (tx_data),
    .pop       (tx_pop),
    .head      (tx_head),
    .count     (tx_count)
  );
endmodule

// File: tb/tb_usb_fifo_responder.sv
// Directed scoreboard bench for usb_fifo_responder: USB strobes and user streams
// are driven on the falling clock edge and outputs are compared there too.
module tb_usb_fifo_responder;
  import usb_pkg::*;

  logic       clkin_50 = 1'b0;
  logic       cpu_resetn = 1'b0;
  logic [7:0] usb_fd_in = '0;
  logic [7:0] usb_fd_out;
  logic       usb_fd_oe;
  logic       usb_cmd_data = 1'b0;
  logic       usb_wen = 1'b1;
  logic       usb_ren = 1'b1;
  logic       usb_empty, usb_full;
  logic [8:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       ovf, unf;
  logic       err_clr = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [8:0] rx_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] rd_byte;

  always #10 clkin_50 = ~clkin_50;

  usb_fifo_responder dut (
    .clkin_50     (clkin_50),
    .cpu_resetn   (cpu_resetn),
    .usb_fd_in    (usb_fd_in),
    .usb_fd_out   (usb_fd_out),
    .usb_fd_oe    (usb_fd_oe),
    .usb_cmd_data (usb_cmd_data),
    .usb_wen      (usb_wen),
    .usb_ren      (usb_ren),
    .usb_empty    (usb_empty),
    .usb_full     (usb_full),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .ovf          (ovf),
    .unf          (unf),
    .err_clr      (err_clr)
  );

  task automatic step();
    @(posedge clkin_50);
    @(negedge clkin_50);
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_oe"},     32'(usb_fd_oe),  32'd0);
    check_output({tag, "_fd_out"}, 32'(usb_fd_out), 32'h00);
    check_output({tag, "_empty"},  32'(usb_empty),  32'd1);
    check_output({tag, "_full"},   32'(usb_full),   32'd0);
    check_output({tag, "_rx_vld"}, 32'(rx_valid),   32'd0);
    check_output({tag, "_tx_rdy"}, 32'(tx_ready),   32'd1);
    check_output({tag, "_ovf"},    32'(ovf),        32'd0);
    check_output({tag, "_unf"},    32'(unf),        32'd0);
  endtask

  task automatic usb_write(input logic cmd, input logic [7:0] b, input int low, input bit accept);
    usb_cmd_data = cmd;
    usb_fd_in    = b;
    usb_wen      = 1'b0;
    repeat (low) step();
    usb_wen = 1'b1;
    step();
    if (accept) rx_q.push_back({cmd, b});
  endtask

  task automatic usb_read(output logic [7:0] b, input string tag);
    usb_ren = 1'b0;
    step();
    check_output({tag, "_oe_hi"}, 32'(usb_fd_oe), 32'd1);
    b = usb_fd_out;
    usb_ren = 1'b1;
    step();
    check_output({tag, "_oe_lo"}, 32'(usb_fd_oe), 32'd0);
  endtask

  task automatic read_expect(input string tag);
    logic [7:0] got;
    logic [7:0] exp;
    exp = (tx_q.size() == 0) ? 8'h00 : tx_q.pop_front();
    usb_read(got, tag);
    check_output({tag, "_byte"}, 32'(got), 32'(exp));
  endtask

  task automatic drain_rx(input int n, input string tag);
    logic [8:0] exp;
    for (int i = 0; i < n; i++) begin
      if (rx_q.size() == 0) begin
        checks++;
        errors++;
        $error("[TB] FAIL %s_sb: observed empty scoreboard expected entry", tag);
      end else begin
        exp = rx_q.pop_front();
        check_output({tag, "_vld"},  32'(rx_valid), 32'd1);
        check_output({tag, "_data"}, 32'(rx_data),  32'(exp));
      end
      rx_ready = 1'b1;
      step();
      rx_ready = 1'b0;
    end
  endtask

  task automatic tx_send(input logic [7:0] b, input string tag);
    check_output({tag, "_tx_rdy"}, 32'(tx_ready), 32'd1);
    tx_data  = b;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    tx_q.push_back(b);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset state
    step();
    step();
    check_reset_values("rst");
    cpu_resetn = 1'b1;
    step();
    step();

    // Single command write with a wide strobe gives exactly one entry
    usb_write(1'b1, 8'hA5, 3, 1'b1);
    step();
    check_output("wr1_data", 32'(rx_data), 32'h1A5);
    drain_rx(1, "wr1");
    check_output("wr1_single", 32'(rx_valid), 32'd0);

    // Show-ahead reads of a preloaded TX FIFO
    tx_send(8'h11, "pre0");
    tx_send(8'h22, "pre1");
    step();
    check_output("pre_not_empty", 32'(usb_empty), 32'd0);
    read_expect("rd0");
    read_expect("rd1");
    step();
    check_output("rd_empty", 32'(usb_empty), 32'd1);
    check_output("rd_fd_zero", 32'(usb_fd_out), 32'h00);

    // Fill RX to capacity, overflow once, then drain in order
    for (int i = 0; i < 16; i++)
      usb_write(i[0], 8'(i * 7 + 3), 1, 1'b1);
    step();
    check_output("fill_full", 32'(usb_full), 32'd1);
    check_output("fill_no_ovf", 32'(ovf), 32'd0);
    usb_write(1'b0, 8'hFF, 1, 1'b0);
    check_output("ovf_set", 32'(ovf), 32'd1);
    drain_rx(16, "drain");
    check_output("drain_done", 32'(rx_valid), 32'd0);
    step();
    check_output("drain_not_full", 32'(usb_full), 32'd0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check_output("ovf_clr", 32'(ovf), 32'd0);

    // Underflow: read strobe on an empty TX FIFO
    read_expect("unf_rd");
    check_output("unf_set", 32'(unf), 32'd1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check_output("unf_clr", 32'(unf), 32'd0);

    // TX full with a same-cycle pop and push
    for (int i = 0; i < 16; i++)
      tx_send(8'(8'h40 + i), "txfill");
    check_output("tx_full_rdy", 32'(tx_ready), 32'd0);
    usb_ren = 1'b0;
    step();
    check_output("swap_head", 32'(usb_fd_out), 32'(tx_q.pop_front()));
    usb_ren  = 1'b1;
    tx_data  = 8'hC3;
    tx_valid = 1'b1;
    #1;
    check_output("swap_rdy", 32'(tx_ready), 32'd1);
    step();
    tx_valid = 1'b0;
    tx_q.push_back(8'hC3);
    #1;
    check_output("swap_still_full", 32'(tx_ready), 32'd0);
    for (int i = 0; i < 16; i++)
      read_expect("swap_rd");
    step();
    check_output("swap_empty", 32'(usb_empty), 32'd1);

    // Reset in the middle of a write strobe that stays low across release
    for (int i = 0; i < 5; i++)
      usb_write(1'b0, 8'(8'h90 + i), 1, 1'b1);
    usb_fd_in = 8'h5A;
    usb_wen   = 1'b0;
    step();
    #2;
    cpu_resetn = 1'b0;
    #1;
    check_reset_values("midrst");
    rx_q.delete();
    step();
    cpu_resetn = 1'b1;
    repeat (3) step();
    check_output("held_no_push", 32'(rx_valid), 32'd0);
    usb_wen = 1'b1;
    step();
    check_output("release_no_push", 32'(rx_valid), 32'd0);
    usb_write(1'b0, 8'h3C, 1, 1'b1);
    drain_rx(1, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
